// File: rtl/norm_shift_pipe.sv
// Two-stage FP significand normaliser: leading-zero count, left shift, exponent adjust.
// Optional flush-to-zero of subnormal results when NORM_FTZ_EN is defined.
module norm_shift_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W:0]   in_man,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic             out_zero,
    output logic             out_denorm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LZC_W = $clog2(MAN_W + 2);
    localparam int CMP_W = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_en;
    logic             s2_en;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W:0]   s1_man;
    logic [TAG_W-1:0] s1_tag;
    logic [LZC_W-1:0] s1_lzc;
    logic [LZC_W-1:0] in_lzc;

    logic             is_zero;
    logic             is_normal;
    logic             is_denorm;
    logic [LZC_W-1:0] shift;
    logic [EXP_W-1:0] nxt_exp;
    logic [MAN_W-1:0] nxt_frac;
    logic             nxt_zero;
    logic             nxt_denorm;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // Upward scan: the highest set bit is the last to write, giving MAN_W+1 for zero input.
    always_comb begin
        in_lzc = LZC_W'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (in_man[i]) begin
                in_lzc = LZC_W'(MAN_W - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_tag   <= '0;
            s1_lzc   <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_exp <= in_exp;
                s1_man <= in_man;
                s1_tag <= in_tag;
                s1_lzc <= in_lzc;
            end
        end
    end

    assign is_zero   = (s1_man == '0);
    assign is_normal = !is_zero && (CMP_W'(s1_lzc) < CMP_W'(s1_exp));
    assign is_denorm = !is_zero && !is_normal;

    // Subnormals shift only as far as the exponent allows, landing at exponent field 0.
    always_comb begin
        shift   = '0;
        nxt_exp = '0;
        if (is_normal) begin
            shift   = s1_lzc;
            nxt_exp = s1_exp - EXP_W'(s1_lzc);
        end else if (is_denorm && (s1_exp != '0)) begin
            shift = LZC_W'(s1_exp - 1'b1);
        end
    end

`ifdef NORM_FTZ_EN
    assign nxt_frac   = is_denorm ? '0 : (s1_man[MAN_W-1:0] << shift);
    assign nxt_zero   = is_zero || is_denorm;
`else
    assign nxt_frac   = s1_man[MAN_W-1:0] << shift;
    assign nxt_zero   = is_zero;
`endif
    assign nxt_denorm = is_denorm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_exp    <= '0;
            out_frac   <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
            out_tag    <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_exp    <= nxt_exp;
                out_frac   <= nxt_frac;
                out_zero   <= nxt_zero;
                out_denorm <= nxt_denorm;
                out_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe: directed test-plan vectors, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_norm_shift_pipe;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int TAG_W = 4;
    localparam int RW    = EXP_W + MAN_W + 2 + TAG_W;

    typedef logic [RW-1:0] res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W:0]   in_man;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_frac;
    logic             out_zero;
    logic             out_denorm;
    logic [TAG_W-1:0] out_tag;

    res_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic held        = 1'b0;
    res_t held_val;

    always #5 clk = ~clk;

    norm_shift_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_exp    (out_exp),
        .out_frac   (out_frac),
        .out_zero   (out_zero),
        .out_denorm (out_denorm),
        .out_tag    (out_tag)
    );

    // Reference: position of the leading one gives the shift needed to reach the hidden bit.
    function automatic res_t model(input logic [MAN_W:0] man, input logic [EXP_W-1:0] e,
                                   input logic [TAG_W-1:0] t);
        int               msb = -1;
        int               z;
        int               sh;
        logic [127:0]     wide;
        logic [EXP_W-1:0] oexp = '0;
        logic [MAN_W-1:0] frac = '0;
        logic             zero = 1'b0;
        logic             den  = 1'b0;
        for (int i = 0; i <= MAN_W; i++) if (man[i]) msb = i;
        if (msb < 0) begin
            zero = 1'b1;
        end else begin
            z = MAN_W - msb;
            if (z < int'(e)) begin
                sh   = z;
                oexp = EXP_W'(int'(e) - z);
            end else begin
                sh  = (e != 0) ? int'(e) - 1 : 0;
                den = 1'b1;
            end
            wide = 128'(man) << sh;
            frac = wide[MAN_W-1:0];
`ifdef NORM_FTZ_EN
            if (den) begin
                frac = '0;
                zero = 1'b1;
            end
`endif
        end
        return {oexp, frac, zero, den, t};
    endfunction

    function automatic res_t observed();
        return {out_exp, out_frac, out_zero, out_denorm, out_tag};
    endfunction

    task automatic check_output(input string name, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // One clock: drive at negedge, sample just after, record acceptance at posedge.
    task automatic apply_stimulus(input logic v, input logic [MAN_W:0] man, input logic [EXP_W-1:0] e,
                                  input logic [TAG_W-1:0] t, input logic ordy,
                                  output logic acc, output logic ov);
        @(negedge clk);
        in_valid  = v;
        in_man    = man;
        in_exp    = e;
        in_tag    = t;
        out_ready = ordy;
        #1;
        ov = out_valid;
        if (held) check_output("hold", {out_valid, observed()}, {1'b1, held_val});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_output("unexpected_output", 128'(out_valid), 128'd0);
            else check_output("result", observed(), exp_q.pop_front());
        end
        held     = out_valid && !out_ready;
        held_val = observed();
        acc      = v && in_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(model(man, e, t));
    endtask

    task automatic drain();
        logic a, o;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) apply_stimulus(1'b0, '0, '0, '0, 1'b1, a, o);
        check_output("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic send(input logic [MAN_W:0] man, input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] t);
        logic a, o;
        apply_stimulus(1'b1, man, e, t, 1'b1, a, o);
        check_output("accept", 128'(a), 128'd1);
        drain();
    endtask

    initial begin
        logic              acc, ov;
        logic [63:0]       r;
        logic [MAN_W:0]    man;
        logic [EXP_W-1:0]  e;
        int                c;
        int                t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_man    = '0;
        in_exp    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset_out_valid", 128'(out_valid), 128'd0);
        check_output("reset_in_ready", 128'(in_ready), 128'd1);
        check_output("reset_outputs", 128'(observed()), 128'd0);

        // Test-plan vectors; the first also checks the two-cycle latency.
        apply_stimulus(1'b1, (MAN_W+1)'(1) << 52, 11'd1023, 4'd1, 1'b1, acc, ov);
        check_output("lat_accept", 128'(acc), 128'd1);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, acc, ov);
        check_output("lat_cycle1", 128'(ov), 128'd0);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, acc, ov);
        check_output("lat_cycle2", 128'(ov), 128'd1);
        check_output("lat_drained", 128'(exp_q.size()), 128'd0);

        send((MAN_W+1)'(1) << 40, 11'd1023, 4'd2);
        send((MAN_W+1)'(1), 11'd100, 4'd3);
        send((MAN_W+1)'(1), 11'd10, 4'd4);
        send('0, 11'd500, 4'd5);
        send((MAN_W+1)'(3), 11'd0, 4'd6);
        send((MAN_W+1)'(1), 11'd53, 4'd7);
        send((MAN_W+1)'(1), 11'd52, 4'd8);

        // Back-pressure: tags 0..5 back to back, out_ready low in cycles 3..6.
        c = 1;
        t = 0;
        while (t < 6 && c < 40) begin
            apply_stimulus(1'b1, (MAN_W+1)'(1) << (45 + t), 11'd1000, TAG_W'(t),
                           !(c >= 3 && c <= 6), acc, ov);
            if (c == 3) check_output("in_ready_full", 128'(acc), 128'd0);
            if (acc) t++;
            c++;
        end
        check_output("bp_all_sent", 128'(t), 128'd6);
        drain();

        // Reset with both stages full and out_ready low.
        apply_stimulus(1'b1, (MAN_W+1)'(5), 11'd700, 4'd9, 1'b0, acc, ov);
        apply_stimulus(1'b1, (MAN_W+1)'(6), 11'd701, 4'd10, 1'b0, acc, ov);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("midreset_out_valid", 128'(out_valid), 128'd0);
        check_output("midreset_in_ready", 128'(in_ready), 128'd1);
        check_output("midreset_outputs", 128'(observed()), 128'd0);
        exp_q.delete();
        held = 1'b0;
        apply_stimulus(1'b1, (MAN_W+1)'(7) << 30, 11'd900, 4'd11, 1'b1, acc, ov);
        check_output("post_reset_accept", 128'(acc), 128'd1);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, acc, ov);
        check_output("post_reset_cycle1", 128'(ov), 128'd0);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, acc, ov);
        check_output("post_reset_cycle2", 128'(ov), 128'd1);

        // Randomized traffic with random valid and random back-pressure.
        for (int i = 0; i < 400; i++) begin
            r   = {$urandom, $urandom};
            r   = r >> $urandom_range(0, 63);
            man = r[MAN_W:0];
            e   = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 60)) : EXP_W'($urandom);
            apply_stimulus($urandom_range(0, 3) != 0, man, e, TAG_W'($urandom),
                           $urandom_range(0, 2) != 0, acc, ov);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
